// File: rtl/uart_boot_loader_pkg.sv
// boot_pkg: shared FSM state encoding, UART framing constants and baud-divider helper.
package boot_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int LEN_BYTES = 2;
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_boot_loader_if.sv
// uart_boot_loader_if: instruction-memory write port driven by the boot loader.
interface uart_boot_loader_if #(parameter int ADDR_W = 10);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master(output imem_we, imem_addr, imem_wdata);
    modport slave(input imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_boot_loader_uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, start-bit glitch rejection and framing-error flag.
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic                      rx_valid,
    output logic                      rx_ferr,
    output logic [UART_DATA_BITS-1:0] rx_byte
);
    typedef enum logic [1:0] {IDLE, START, BITS, STOP} rx_state_t;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    rx_state_t st;
    logic [2:0] sync;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    // sync[1] is the synchronized line, sync[2] its previous value for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st <= IDLE;
            sync <= 3'b111;
            cnt <= '0;
            bit_idx <= '0;
            rx_byte <= '0;
            rx_valid <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            sync <= {sync[1:0], rx};
            rx_valid <= 1'b0;
            rx_ferr <= 1'b0;
            case (st)
                IDLE: if (sync[2] && !sync[1]) begin
                    st <= START;
                    cnt <= '0;
                end
                START: if (cnt == HALF) begin
                    cnt <= '0;
                    bit_idx <= '0;
                    st <= sync[1] ? IDLE : BITS;
                end else cnt <= cnt + 1'b1;
                BITS: if (cnt == FULL) begin
                    cnt <= '0;
                    rx_byte <= {sync[1], rx_byte[UART_DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'(UART_DATA_BITS - 1)) st <= STOP;
                end else cnt <= cnt + 1'b1;
                STOP: if (cnt == FULL) begin
                    st <= IDLE;
                    rx_valid <= sync[1];
                    rx_ferr <= !sync[1];
                end else cnt <= cnt + 1'b1;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: loads a length-prefixed LE word image from UART into imem, then releases core reset.
// Optional BOOT_CHECKSUM_EN adds a trailing XOR checksum byte checked in CHK.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD = 115200,
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rx,
    input  logic                     boot_req,
    uart_boot_loader_if.master       imem,
    output logic                     core_rst,
    output logic                     boot_done,
    output logic                     boot_err,
    output logic [ADDR_W:0]          words_loaded
);
    localparam int CPB = clks_per_bit(CLK_FREQ_HZ, BAUD);
    state_t state;
    logic rx_valid, rx_ferr, wr_pend;
    logic [7:0] rx_byte;
    logic [15:0] len;
    logic [1:0] byte_idx;
    logic [31:0] word;
    logic [15:0] n;
    logic n_bad;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] xsum;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk(clk), .rst(rst), .rx(uart_rx),
        .rx_valid(rx_valid), .rx_ferr(rx_ferr), .rx_byte(rx_byte)
    );

    assign n = {rx_byte, len[7:0]};
    assign n_bad = (n == 16'd0) || (32'(n) > 32'(IMEM_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LEN_LO;
            len <= '0;
            byte_idx <= '0;
            word <= '0;
            wr_pend <= 1'b0;
            imem.imem_we <= 1'b0;
            imem.imem_addr <= '0;
            imem.imem_wdata <= '0;
            core_rst <= 1'b0;
            boot_done <= 1'b0;
            boot_err <= 1'b0;
            words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
            xsum <= '0;
`endif
        end else begin
            imem.imem_we <= 1'b0;
            wr_pend <= 1'b0;
            case (state)
                LEN_LO: if (rx_ferr) begin
                    state <= ERR;
                    boot_err <= 1'b1;
                end else if (rx_valid) begin
                    len[7:0] <= rx_byte;
                    state <= LEN_HI;
                end
                LEN_HI: if (rx_ferr || (rx_valid && n_bad)) begin
                    state <= ERR;
                    boot_err <= 1'b1;
                end else if (rx_valid) begin
                    len[15:8] <= rx_byte;
                    state <= DATA;
                    byte_idx <= '0;
                    imem.imem_addr <= '0;
                    words_loaded <= '0;
`ifdef BOOT_CHECKSUM_EN
                    xsum <= '0;
`endif
                end
                DATA: if (rx_ferr) begin
                    state <= ERR;
                    boot_err <= 1'b1;
                end else begin
                    if (rx_valid) begin
                        word <= {rx_byte, word[31:8]};
                        byte_idx <= byte_idx + 1'b1;
                        wr_pend <= byte_idx == 2'd3;
`ifdef BOOT_CHECKSUM_EN
                        xsum <= xsum ^ rx_byte;
`endif
                    end
                    if (wr_pend) begin
                        imem.imem_we <= 1'b1;
                        imem.imem_wdata <= word;
                    end
                    // address and count advance in the cycle after the strobe
                    if (imem.imem_we) begin
                        imem.imem_addr <= imem.imem_addr + 1'b1;
                        words_loaded <= words_loaded + 1'b1;
                        if (words_loaded + 1'b1 == (ADDR_W+1)'(len)) begin
`ifdef BOOT_CHECKSUM_EN
                            state <= CHK;
`else
                            state <= DONE;
                            core_rst <= 1'b1;
                            boot_done <= 1'b1;
`endif
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHK: if (rx_ferr || (rx_valid && rx_byte != xsum)) begin
                    state <= ERR;
                    boot_err <= 1'b1;
                end else if (rx_valid) begin
                    state <= DONE;
                    core_rst <= 1'b1;
                    boot_done <= 1'b1;
                end
`endif
                DONE, ERR: if (boot_req) begin
                    state <= LEN_LO;
                    core_rst <= 1'b0;
                    boot_done <= 1'b0;
                    boot_err <= 1'b0;
                    words_loaded <= '0;
                    imem.imem_addr <= '0;
                    byte_idx <= '0;
                end
                default: state <= LEN_LO;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed boot-loader scenarios at 10 clocks per bit, IMEM_DEPTH=16.
module tb_uart_boot_loader;
    localparam int AW = 4;
    logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, boot_req = 1'b0;
    logic core_rst, boot_done, boot_err;
    logic [AW:0] words_loaded;
    int checks = 0, errors = 0, cyc = 0, wr_total = 0, we_cyc = -100, rise_cyc = -100, bad_we = 0, base = 0;
    logic prev_we = 1'b0, prev_core = 1'b0;
    logic [AW-1:0] log_addr [64];
    logic [31:0] log_data [64];
    logic [7:0] img [$];

    uart_boot_loader_if #(.ADDR_W(AW)) imem ();

    uart_boot_loader #(.CLK_FREQ_HZ(1000000), .BAUD(100000), .IMEM_DEPTH(16), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .boot_req(boot_req), .imem(imem),
        .core_rst(core_rst), .boot_done(boot_done), .boot_err(boot_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (imem.imem_we) begin
            if (wr_total < 64) begin
                log_addr[wr_total] = imem.imem_addr;
                log_data[wr_total] = imem.imem_wdata;
            end
            wr_total++;
            we_cyc = cyc;
        end
        if (imem.imem_we && prev_we) bad_we++;
        if (core_rst && !prev_core) rise_cyc = cyc;
        prev_we = imem.imem_we;
        prev_core = core_rst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        uart_rx = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(10);
        end
        uart_rx = stop;
        tick(10);
        uart_rx = 1'b1;
        tick(2);
    endtask

    task automatic send_img();
        logic [7:0] x;
        x = 8'h00;
        foreach (img[i]) begin
            send_byte(img[i]);
            if (i >= 2) x = x ^ img[i];
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(boot_done || boot_err) && n < 200) begin
            tick(1);
            n++;
        end
        chk("end_reached", 32'(boot_done | boot_err), 32'd1);
        tick(3);
    endtask

    task automatic do_boot_req();
        boot_req = 1'b1;
        tick(1);
        boot_req = 1'b0;
        tick(1);
    endtask

    initial begin
        #1 rst = 1'b0;
        tick(3);
        chk("rst_we", 32'(imem.imem_we), 32'd0);
        chk("rst_addr", 32'(imem.imem_addr), 32'd0);
        chk("rst_wdata", imem.imem_wdata, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd0);
        chk("rst_done", 32'(boot_done), 32'd0);
        chk("rst_err", 32'(boot_err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b1;
        tick(3);

        base = wr_total;
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        send_img();
        wait_end();
        chk("img1_writes", 32'(wr_total - base), 32'd2);
        chk("img1_addr0", 32'(log_addr[base]), 32'd0);
        chk("img1_data0", log_data[base], 32'h00A00513);
        chk("img1_addr1", 32'(log_addr[base+1]), 32'd1);
        chk("img1_data1", log_data[base+1], 32'h00100593);
        chk("img1_words", 32'(words_loaded), 32'd2);
        chk("img1_core_rst", 32'(core_rst), 32'd1);
        chk("img1_done", 32'(boot_done), 32'd1);
        chk("img1_err", 32'(boot_err), 32'd0);
`ifndef BOOT_CHECKSUM_EN
        chk("img1_release_lat", 32'(rise_cyc - we_cyc), 32'd1);
`endif

        do_boot_req();
        chk("req_core_rst", 32'(core_rst), 32'd0);
        chk("req_done", 32'(boot_done), 32'd0);
        chk("req_words", 32'(words_loaded), 32'd0);

        base = wr_total;
        img = '{8'h00, 8'h00};
        send_img();
        wait_end();
        chk("len0_err", 32'(boot_err), 32'd1);
        chk("len0_core_rst", 32'(core_rst), 32'd0);
        chk("len0_writes", 32'(wr_total - base), 32'd0);

        do_boot_req();
        img = '{8'h11, 8'h00};
        send_img();
        wait_end();
        chk("len17_err", 32'(boot_err), 32'd1);
        chk("len17_core_rst", 32'(core_rst), 32'd0);
        chk("len17_writes", 32'(wr_total - base), 32'd0);

        do_boot_req();
        base = wr_total;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h05);
        send_byte(8'hA0);
        send_byte(8'h00);
        send_byte(8'h93, 1'b0);
        wait_end();
        chk("ferr_err", 32'(boot_err), 32'd1);
        chk("ferr_core_rst", 32'(core_rst), 32'd0);
        chk("ferr_writes", 32'(wr_total - base), 32'd1);
        chk("ferr_addr0", 32'(log_addr[base]), 32'd0);
        chk("ferr_data0", log_data[base], 32'h00A00513);

        do_boot_req();
        base = wr_total;
        img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_img();
        wait_end();
        chk("reload_done", 32'(boot_done), 32'd1);
        chk("reload_addr0", 32'(log_addr[base]), 32'd0);
        chk("reload_data0", log_data[base], 32'hDEADBEEF);

        do_boot_req();
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(30);
        chk("glitch_err", 32'(boot_err), 32'd0);
        chk("glitch_done", 32'(boot_done), 32'd0);
        base = wr_total;
        img = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_img();
        wait_end();
        chk("glitch_img_done", 32'(boot_done), 32'd1);
        chk("glitch_img_data", log_data[base], 32'h12345678);
        chk("glitch_img_words", 32'(words_loaded), 32'd1);

        do_boot_req();
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'h11);
        send_byte(8'h22);
        uart_rx = 1'b0;
        tick(15);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_we", 32'(imem.imem_we), 32'd0);
        chk("mid_rst_addr", 32'(imem.imem_addr), 32'd0);
        chk("mid_rst_wdata", imem.imem_wdata, 32'd0);
        chk("mid_rst_core_rst", 32'(core_rst), 32'd0);
        chk("mid_rst_done", 32'(boot_done), 32'd0);
        chk("mid_rst_err", 32'(boot_err), 32'd0);
        chk("mid_rst_words", 32'(words_loaded), 32'd0);
        uart_rx = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(3);
        base = wr_total;
        img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_img();
        wait_end();
        chk("post_rst_done", 32'(boot_done), 32'd1);
        chk("post_rst_addr0", 32'(log_addr[base]), 32'd0);
        chk("post_rst_data0", log_data[base], 32'hDDCCBBAA);

`ifdef BOOT_CHECKSUM_EN
        do_boot_req();
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (img[i]) send_byte(img[i]);
        send_byte(8'h44);
        wait_end();
        chk("csum_ok_done", 32'(boot_done), 32'd1);
        chk("csum_ok_core_rst", 32'(core_rst), 32'd1);
        do_boot_req();
        foreach (img[i]) send_byte(img[i]);
        send_byte(8'h45);
        wait_end();
        chk("csum_bad_err", 32'(boot_err), 32'd1);
        chk("csum_bad_core_rst", 32'(core_rst), 32'd0);
`endif

        chk("no_back_to_back_we", 32'(bad_we), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
